// File: rtl/sw_watch_pkg.sv
// Shared definitions for the stopwatch/watch mode controller:
// state encodings, watch field codes, button arbitration result and
// small helpers that map SET states to field codes and neighbours.
package sw_watch_pkg;

  localparam int DEF_CLK_HZ = 100_000_000;

  typedef enum logic [2:0] {
    ST_SW    = 3'd0,
    ST_WATCH = 3'd1,
    ST_SET_H = 3'd2,
    ST_SET_M = 3'd3,
    ST_SET_S = 3'd4
  } state_e;

  localparam logic [1:0] FIELD_HOUR = 2'b00;
  localparam logic [1:0] FIELD_MIN  = 2'b01;
  localparam logic [1:0] FIELD_SEC  = 2'b10;

  // Winning button after priority arbitration (mode > l > r > u > d).
  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_MODE = 3'd1,
    ACT_L    = 3'd2,
    ACT_R    = 3'd3,
    ACT_U    = 3'd4,
    ACT_D    = 3'd5
  } act_e;

  function automatic logic is_set(input state_e s);
    return (s == ST_SET_H) || (s == ST_SET_M) || (s == ST_SET_S);
  endfunction

  // Field to the left, wrapping H -> S.
  function automatic state_e field_left(input state_e s);
    case (s)
      ST_SET_H: return ST_SET_S;
      ST_SET_M: return ST_SET_H;
      default:  return ST_SET_M;
    endcase
  endfunction

  // Field to the right, wrapping S -> H.
  function automatic state_e field_right(input state_e s);
    case (s)
      ST_SET_H: return ST_SET_M;
      ST_SET_M: return ST_SET_S;
      default:  return ST_SET_H;
    endcase
  endfunction

  // Field code shown to the display mux; hour outside SET states.
  function automatic logic [1:0] field_code(input state_e s);
    case (s)
      ST_SET_M: return FIELD_MIN;
      ST_SET_S: return FIELD_SEC;
      default:  return FIELD_HOUR;
    endcase
  endfunction

endpackage

// File: rtl/sw_watch_mode_ctrl_tick_gen.sv
// tick_gen: free-running divider producing a one-cycle tick every DIV
// cycles. i_clr restarts the count so the next tick is DIV cycles away.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  assign o_tick = (r_cnt == TERM);

  // Count 0..DIV-1, wrap to 0 on the terminal count or on clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sw_watch_mode_ctrl.sv
// sw_watch_mode_ctrl: arbitrates debounced button pulses between the
// stopwatch control path and the watch time-set path, and drives the
// display select / set-field blink for the FND mux.
// Optional feature: define SW_WATCH_AUTO_EXIT_EN to leave a SET state
// after TIMEOUT_S seconds without any button pulse.
// All outputs are registered; o_dbg_state exposes the FSM state.
module sw_watch_mode_ctrl
  import sw_watch_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int BLINK_HZ  = 2,
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_l,
  input  logic       i_btn_r,
  input  logic       i_btn_u,
  input  logic       i_btn_d,
  output logic       o_sw_rs,
  output logic       o_sw_clr,
  output logic       o_w_inc,
  output logic       o_w_dec,
  output logic       o_disp_sel,
  output logic       o_set_mode,
  output logic [1:0] o_field_sel,
  output logic       o_blink,
  output logic [2:0] o_dbg_state
);

  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);

  state_e     r_state;
  state_e     w_next;
  act_e       w_act;
  logic       w_sw_rs, w_sw_clr, w_w_inc, w_w_dec;
  logic       w_blink_restart, w_blink_tick, w_expire;
  logic       r_sw_rs, r_sw_clr, r_w_inc, r_w_dec;
  logic       r_disp_sel, r_set_mode, r_blink;
  logic [1:0] r_field_sel;

  // Pick the single highest-priority button; the rest are dropped.
  always_comb begin
    w_act = ACT_NONE;
    if (i_btn_mode)   w_act = ACT_MODE;
    else if (i_btn_l) w_act = ACT_L;
    else if (i_btn_r) w_act = ACT_R;
    else if (i_btn_u) w_act = ACT_U;
    else if (i_btn_d) w_act = ACT_D;
  end

  // Next state and next output pulses from the arbitrated action.
  always_comb begin
    w_next   = r_state;
    w_sw_rs  = 1'b0;
    w_sw_clr = 1'b0;
    w_w_inc  = 1'b0;
    w_w_dec  = 1'b0;
    case (r_state)
      ST_SW: begin
        case (w_act)
          ACT_MODE: w_next   = ST_WATCH;
          ACT_U:    w_sw_rs  = 1'b1;
          ACT_D:    w_sw_clr = 1'b1;
          default:  ;
        endcase
      end
      ST_WATCH: begin
        case (w_act)
          ACT_MODE: w_next = ST_SW;
          ACT_L:    w_next = ST_SET_H;
          default:  ;
        endcase
      end
      ST_SET_H, ST_SET_M, ST_SET_S: begin
        case (w_act)
          ACT_MODE: w_next  = ST_WATCH;
          ACT_L:    w_next  = field_left(r_state);
          ACT_R:    w_next  = field_right(r_state);
          ACT_U:    w_w_inc = 1'b1;
          ACT_D:    w_w_dec = 1'b1;
          default:  if (w_expire) w_next = ST_WATCH;
        endcase
      end
      default: w_next = ST_WATCH;
    endcase
  end

  // Blink restarts visible on SET entry, field change, inc/dec, and is
  // held visible whenever the next state is outside SET.
  assign w_blink_restart = !is_set(w_next) || (w_next != r_state) || w_w_inc || w_w_dec;

  tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_blink_restart),
    .o_tick (w_blink_tick)
  );

`ifdef SW_WATCH_AUTO_EXIT_EN
  localparam int TO_W = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

  logic            w_any_btn, w_to_clr, w_sec_tick;
  logic [TO_W-1:0] r_to_cnt;

  assign w_any_btn = i_btn_mode | i_btn_l | i_btn_r | i_btn_u | i_btn_d;
  // Idle time is measured only inside SET and restarts on any pulse.
  assign w_to_clr  = !is_set(r_state) || w_any_btn;

  tick_gen #(.DIV(CLK_HZ)) u_sec_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_to_clr),
    .o_tick (w_sec_tick)
  );

  // Whole seconds elapsed in SET without a button pulse.
  always_ff @(posedge clk) begin
    if (!rst || w_to_clr) begin
      r_to_cnt <= '0;
    end else if (w_sec_tick) begin
      r_to_cnt <= (r_to_cnt == TO_LAST) ? '0 : r_to_cnt + 1'b1;
    end
  end

  // Expiry is the tick that completes the last second.
  assign w_expire = is_set(r_state) && w_sec_tick && (r_to_cnt == TO_LAST);
`else
  assign w_expire = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_SW;
      r_sw_rs     <= 1'b0;
      r_sw_clr    <= 1'b0;
      r_w_inc     <= 1'b0;
      r_w_dec     <= 1'b0;
      r_disp_sel  <= 1'b0;
      r_set_mode  <= 1'b0;
      r_field_sel <= FIELD_HOUR;
      r_blink     <= 1'b1;
    end else begin
      r_state     <= w_next;
      r_sw_rs     <= w_sw_rs;
      r_sw_clr    <= w_sw_clr;
      r_w_inc     <= w_w_inc;
      r_w_dec     <= w_w_dec;
      r_disp_sel  <= (w_next != ST_SW);
      r_set_mode  <= is_set(w_next);
      r_field_sel <= field_code(w_next);
      if (w_blink_restart) begin
        r_blink <= 1'b1;
      end else if (w_blink_tick) begin
        r_blink <= ~r_blink;
      end
    end
  end

  assign o_sw_rs     = r_sw_rs;
  assign o_sw_clr    = r_sw_clr;
  assign o_w_inc     = r_w_inc;
  assign o_w_dec     = r_w_dec;
  assign o_disp_sel  = r_disp_sel;
  assign o_set_mode  = r_set_mode;
  assign o_field_sel = r_field_sel;
  assign o_blink     = r_blink;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sw_watch_mode_ctrl.sv
// Bench for sw_watch_mode_ctrl with small clock parameters: blink toggles
// every 2 cycles, SET timeout is 3000 cycles when SW_WATCH_AUTO_EXIT_EN
// is defined. A behavioural model computes expected outputs per edge.
module tb_sw_watch_mode_ctrl;

  localparam int CLK_HZ    = 1000;
  localparam int BLINK_HZ  = 250;
  localparam int TIMEOUT_S = 3;
  localparam int HALF      = CLK_HZ / (2 * BLINK_HZ);
  localparam int TO_CYC    = TIMEOUT_S * CLK_HZ;
`ifdef SW_WATCH_AUTO_EXIT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_mode = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic sw_rs, sw_clr, w_inc, w_dec, disp_sel, set_mode, blink;
  logic [1:0] field_sel;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  sw_watch_mode_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .BLINK_HZ  (BLINK_HZ),
    .TIMEOUT_S (TIMEOUT_S)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_btn_mode  (btn_mode),
    .i_btn_l     (btn_l),
    .i_btn_r     (btn_r),
    .i_btn_u     (btn_u),
    .i_btn_d     (btn_d),
    .o_sw_rs     (sw_rs),
    .o_sw_clr    (sw_clr),
    .o_w_inc     (w_inc),
    .o_w_dec     (w_dec),
    .o_disp_sel  (disp_sel),
    .o_set_mode  (set_mode),
    .o_field_sel (field_sel),
    .o_blink     (blink),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // {rs, clr, inc, dec, disp, set, field[1:0], blink}
  logic [8:0] exp_q[$];

  // Model: mode 0 = stopwatch view, 1 = watch view, 2 = setting field.
  int   m_mode  = 0;
  int   m_field = 0;   // 0 hour, 1 min, 2 sec
  int   m_since = 0;   // cycles since blink restart
  int   m_idle  = 0;   // cycles in SET since entry / last pulse
  logic m_blink = 1'b1;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rn, input bit mo, input bit bl, input bit br,
                            input bit bu, input bit bd);
    logic rs, cl, inc, dec;
    logic [1:0] fe;
    bit was_set, restart, any;
    rs = 1'b0; cl = 1'b0; inc = 1'b0; dec = 1'b0;
    restart = 1'b0;
    any = mo | bl | br | bu | bd;
    was_set = (m_mode == 2);
    if (!rn) begin
      m_mode = 0; m_field = 0; m_since = 0; m_idle = 0; m_blink = 1'b1;
    end else begin
      if (m_mode == 0) begin
        if (mo) m_mode = 1;
        else if (bl || br) ;
        else if (bu) rs = 1'b1;
        else if (bd) cl = 1'b1;
      end else if (m_mode == 1) begin
        if (mo) m_mode = 0;
        else if (bl) begin m_mode = 2; m_field = 0; m_idle = 0; restart = 1'b1; end
      end else begin
        if (any) m_idle = 0; else m_idle++;
        if (mo) m_mode = 1;
        else if (bl) begin m_field = (m_field + 2) % 3; restart = 1'b1; end
        else if (br) begin m_field = (m_field + 1) % 3; restart = 1'b1; end
        else if (bu) begin inc = 1'b1; restart = 1'b1; end
        else if (bd) begin dec = 1'b1; restart = 1'b1; end
        else if (AUTO && m_idle == TO_CYC) m_mode = 1;
      end
      if (m_mode == 2 && was_set && !restart) m_since++;
      else m_since = 0;
      m_blink = (m_mode != 2) || (((m_since / HALF) % 2) == 0);
    end
    fe = (m_mode == 2) ? 2'(m_field) : 2'd0;
    exp_q.push_back({rs, cl, inc, dec, (m_mode != 0), (m_mode == 2), fe, m_blink});
  endtask

  task automatic check_outputs();
    logic [8:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL exp_q_empty got=0 exp=1");
      return;
    end
    e = exp_q.pop_front();
    chk("sw_rs",     {1'b0, sw_rs},    {1'b0, e[8]});
    chk("sw_clr",    {1'b0, sw_clr},   {1'b0, e[7]});
    chk("w_inc",     {1'b0, w_inc},    {1'b0, e[6]});
    chk("w_dec",     {1'b0, w_dec},    {1'b0, e[5]});
    chk("disp_sel",  {1'b0, disp_sel}, {1'b0, e[4]});
    chk("set_mode",  {1'b0, set_mode}, {1'b0, e[3]});
    chk("field_sel", field_sel,        e[2:1]);
    chk("blink",     {1'b0, blink},    {1'b0, e[0]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit rn, input bit mo, input bit bl, input bit br,
                      input bit bu, input bit bd);
    rst = rn; btn_mode = mo; btn_l = bl; btn_r = br; btn_u = bu; btn_d = bd;
    @(posedge clk);
    model_edge(rn, mo, bl, br, bu, bd);
    #1;
    check_outputs();
    rst = 1'b1; btn_mode = 1'b0; btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(2);
    // stopwatch run/stop and clear
    step(1, 0, 0, 0, 1, 0); idle(1);
    step(1, 0, 0, 0, 0, 1); idle(1);
    // l/r ignored in stopwatch view, priority l over u drops u
    step(1, 0, 1, 0, 1, 0); step(1, 0, 0, 1, 0, 0);
    // watch, enter SET_H, walk right with wrap
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1);   // u/d ignored in watch view
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0); step(1, 0, 0, 1, 0, 0); step(1, 0, 0, 1, 0, 0);
    // SET_M: inc then dec with blink restart and toggling
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0); idle(5);
    step(1, 0, 0, 0, 0, 1); idle(5);
    // walk left with wrap: M -> H -> S -> M -> H
    step(1, 0, 1, 0, 0, 0); step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0); step(1, 0, 1, 0, 0, 0);
    // SET_H: mode and u together -> watch, no inc
    step(1, 1, 0, 0, 1, 0); idle(2);
    // timeout window in SET_S
    step(1, 0, 1, 0, 0, 0); step(1, 0, 1, 0, 0, 0);
    idle(TO_CYC - 1);
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    if (m_mode != 2) begin step(1, 0, 1, 0, 0, 0); step(1, 0, 1, 0, 0, 0); end
    // d on the same cycle as expiry keeps SET and fires dec
    idle(TO_CYC - 1);
    step(1, 0, 0, 0, 0, 1);
    idle(10000);
    // reset while in SET_S with u asserted
    if (m_mode == 0) step(1, 1, 0, 0, 0, 0);
    if (m_mode == 1) step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3 && m_field != 2; i++) step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);   // back in stopwatch: u -> run/stop
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(0, 0, 0, 0, $urandom_range(0, 1), 0);
      end else if (r < 40) begin
        step(1, ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0));
      end else begin
        step(1, 0, 0, 0, 0, 0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
